// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer states and counter sizing helper
package rst_seq_pkg;

   typedef enum logic [1:0] {HOLD, WAIT, GAP, DONE} state_t;

   // smallest counter width able to reach max(h, g, t) - 1
   function automatic int req_cnt_width(int h, int g, int t);
      int m;
      m = h > g ? h : g;
      m = m > t ? m : t;
      return m > 1 ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: clearable enabled up-counter with terminal compare
module rst_seq_cnt #(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [w-1:0] lim,
   output logic         hit
);

   logic [w-1:0] cnt;

   // count while enabled; a clear takes priority over counting
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;

   assign hit = cnt == lim;

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset release aligned to per-domain clock enables
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int n              = 4,
   parameter int hold_cycles    = 16,
   parameter int gap_cycles     = 4,
   parameter int timeout_cycles = 0,
   parameter int cnt_width      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic [n-1:0]      cke,
   output logic [n-1:0]      rst_out,
   output logic [$clog2(n):0] stage,
   output logic              done,
   output logic [n-1:0]      err
);

   localparam int sw = $clog2(n) + 1;
   localparam logic [cnt_width-1:0] hold_lim = cnt_width'(hold_cycles - 1);
   localparam logic [cnt_width-1:0] gap_lim  = cnt_width'((gap_cycles > 0 ? gap_cycles : 1) - 1);
   localparam logic [cnt_width-1:0] to_lim   = cnt_width'((timeout_cycles > 0 ? timeout_cycles : 1) - 1);

   if (req_cnt_width(hold_cycles, gap_cycles, timeout_cycles) > cnt_width) begin : g_width_chk
      $error("rst_seq: cnt_width too small for the cycle parameters");
   end

   state_t               state, nxt;
   logic                 clr, hit, cur, last, rel;
   logic [n-1:0]         sel;
   logic [cnt_width-1:0] lim;

   assign sel  = n'(1) << stage;
   assign cur  = |(cke & sel);
   assign last = stage == sw'(n - 1);
   assign rel  = state == WAIT && !restart && (cur || (timeout_cycles != 0 && hit));
   assign lim  = state == HOLD ? hold_lim : state == GAP ? gap_lim : to_lim;

   rst_seq_cnt #(.w(cnt_width)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (state != DONE),
      .lim (lim),
      .hit (hit)
   );

   // state register
   always_ff @(posedge clk)
      if (rst) state <= HOLD;
      else state <= nxt;

   // next state; every transition restarts the shared counter
   always_comb begin
      nxt = state;
      clr = 1'b0;
      if (restart) begin
         nxt = HOLD;
         clr = 1'b1;
      end else if (rel) begin
         nxt = last ? DONE : gap_cycles == 0 ? WAIT : GAP;
         clr = 1'b1;
      end else if ((state == HOLD || state == GAP) && hit) begin
         nxt = WAIT;
         clr = 1'b1;
      end
   end

   // release, stage and sticky error registers; restart keeps err
   always_ff @(posedge clk)
      if (rst || restart) begin
         rst_out <= '1;
         stage   <= '0;
         done    <= 1'b0;
         err     <= rst ? '0 : err;
      end else begin
         done <= nxt == DONE;
         if (rel) begin
            rst_out <= rst_out & ~sel;
            err     <= err | (cur ? '0 : sel);
         end
         if ((rel && (last || gap_cycles == 0)) || (state == GAP && hit)) stage <= stage + 1'b1;
      end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: two configurations of rst_seq against an edge-count model
module tb_rst_seq;

   localparam int na = 3, ha = 3, ga = 0, ta = 4, swa = $clog2(na) + 1;
   localparam int nb = 2, hb = 4, gb = 3, tob = 0, swb = $clog2(nb) + 1;

   logic clk = 0, rst = 1, restart = 0;
   logic [na-1:0]  cke_a = '0, ro_a, err_a;
   logic [nb-1:0]  cke_b = '0, ro_b, err_b;
   logic [swa-1:0] st_a;
   logic [swb-1:0] st_b;
   logic done_a, done_b;

   int checks = 0, errors = 0, e = 0;
   int pn[2] = '{na, nb};
   int ph[2] = '{ha, hb};
   int pg[2] = '{ga, gb};
   int pt[2] = '{ta, tob};
   int m_t[2], m_k[2], m_arm[2];
   logic [3:0] m_err[2];
   int fa[na], fb[nb], fda, fdb;

   rst_seq #(.n(na), .hold_cycles(ha), .gap_cycles(ga), .timeout_cycles(ta), .cnt_width(4)) dut_a (
      .clk(clk), .rst(rst), .restart(restart), .cke(cke_a),
      .rst_out(ro_a), .stage(st_a), .done(done_a), .err(err_a));

   rst_seq #(.n(nb), .hold_cycles(hb), .gap_cycles(gb), .timeout_cycles(tob), .cnt_width(4)) dut_b (
      .clk(clk), .rst(rst), .restart(restart), .cke(cke_b),
      .rst_out(ro_b), .stage(st_b), .done(done_b), .err(err_b));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, got, exp);
      end
   endtask

   // model: t counts edges since the sequence (re)started; the armed domain
   // waits on edges arm+1.., and the next is armed gap edges after a release
   task automatic step(input int i, input logic [3:0] c);
      if (rst || restart) begin
         m_t[i] = 0;
         m_k[i] = 0;
         m_arm[i] = ph[i];
         if (rst) m_err[i] = '0;
      end else begin
         m_t[i]++;
         if (m_k[i] < pn[i] && m_t[i] > m_arm[i]) begin
            if (c[m_k[i]] || (pt[i] != 0 && m_t[i] - m_arm[i] == pt[i])) begin
               if (!c[m_k[i]]) m_err[i][m_k[i]] = 1'b1;
               m_k[i]++;
               m_arm[i] = m_t[i] + pg[i];
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_ro(input int i);
      return ((1 << pn[i]) - 1) & ~((1 << m_k[i]) - 1);
   endfunction

   function automatic logic [31:0] exp_st(input int i);
      return (m_k[i] > 0 && m_k[i] < pn[i] && m_t[i] < m_arm[i]) ? m_k[i] - 1 : m_k[i];
   endfunction

   task automatic cmp();
      chk("a_rst_out", 32'(ro_a), exp_ro(0));
      chk("a_stage", 32'(st_a), exp_st(0));
      chk("a_done", 32'(done_a), 32'(m_k[0] == na));
      chk("a_err", 32'(err_a), 32'(m_err[0]));
      chk("b_rst_out", 32'(ro_b), exp_ro(1));
      chk("b_stage", 32'(st_b), exp_st(1));
      chk("b_done", 32'(done_b), 32'(m_k[1] == nb));
      chk("b_err", 32'(err_b), 32'(m_err[1]));
   endtask

   task automatic clr_f();
      for (int i = 0; i < na; i++) fa[i] = -1;
      for (int i = 0; i < nb; i++) fb[i] = -1;
      fda = -1;
      fdb = -1;
   endtask

   task automatic tick(input logic [na-1:0] ca, input logic [nb-1:0] cb);
      cke_a = ca;
      cke_b = cb;
      @(posedge clk);
      step(0, 4'(ca));
      step(1, 4'(cb));
      e++;
      #1;
      if (rst || restart) clr_f();
      for (int i = 0; i < na; i++) if (!ro_a[i] && fa[i] < 0) fa[i] = e;
      for (int i = 0; i < nb; i++) if (!ro_b[i] && fb[i] < 0) fb[i] = e;
      if (done_a && fda < 0) fda = e;
      if (done_b && fdb < 0) fdb = e;
      cmp();
   endtask

   task automatic do_reset();
      rst = 1;
      restart = 0;
      tick('0, '0);
      tick('0, '0);
      rst = 0;
      e = 0;
      clr_f();
   endtask

   initial begin
      do_reset();
      for (int j = 1; j <= 12; j++) tick('1, '1);
      chk("b_rel0_edge", fb[0], 5);
      chk("b_rel1_edge", fb[1], 9);
      chk("b_done_edge", fdb, 9);
      chk("b_stage_final", 32'(st_b), 2);
      chk("a_rel0_edge", fa[0], 4);
      chk("a_rel2_edge", fa[2], 6);

      do_reset();
      for (int j = 1; j <= 24; j++) tick('0, {j >= 21, 1'b1});
      chk("a_forced0_edge", fa[0], 7);
      chk("a_forced1_edge", fa[1], 11);
      chk("a_forced2_edge", fa[2], 15);
      chk("a_forced_done", fda, 15);
      chk("a_forced_err", 32'(err_a), 7);
      chk("b_late_rel1", fb[1], 21);
      chk("b_late_done", fdb, 21);
      chk("b_late_err", 32'(err_b), 0);
      restart = 1;
      tick('0, '0);
      restart = 0;
      chk("a_err_kept", 32'(err_a), 7);
      chk("a_ro_restart", 32'(ro_a), 7);
      chk("a_done_restart", 32'(done_a), 0);

      do_reset();
      for (int j = 1; j <= 14; j++) begin
         restart = j == 7;
         tick('0, '1);
      end
      restart = 0;
      chk("b_restart_rel0", fb[0], 12);
      chk("a_restart_beats_timeout", fa[0], 14);

      do_reset();
      for (int j = 1; j <= 10; j++) tick({2'b00, j == 7}, '1);
      chk("a_coincide_edge", fa[0], 7);
      chk("a_coincide_err", 32'(err_a[0]), 0);

      do_reset();
      for (int j = 1; j <= 7; j++) tick('1, '1);
      rst = 1;
      tick('1, '1);
      chk("b_midgap_ro", 32'(ro_b), 3);
      chk("b_midgap_stage", 32'(st_b), 0);
      chk("b_midgap_done", 32'(done_b), 0);
      rst = 0;
      e = 0;
      clr_f();
      for (int j = 1; j <= 6; j++) tick('1, '1);
      chk("b_rerun_rel0", fb[0], 5);

      do_reset();
      repeat (3000) begin
         rst = $urandom_range(499) == 0;
         restart = $urandom_range(149) == 0;
         tick(3'($urandom & $urandom), 2'($urandom & $urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
